// File: rtl/core_icache_pkg.sv
// core_icache_pkg: shared state encoding and address-field extraction for the instruction cache.
package core_icache_pkg;

    localparam int MAX_AW = 128;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, FLUSH} state_t;

    function automatic logic [MAX_AW-1:0] addr_offset(input logic [MAX_AW-1:0] addr, input int ow);
        return addr & ((MAX_AW'(1) << ow) - MAX_AW'(1));
    endfunction

    function automatic logic [MAX_AW-1:0] addr_index(input logic [MAX_AW-1:0] addr, input int iw, input int ow);
        return (addr >> ow) & ((MAX_AW'(1) << iw) - MAX_AW'(1));
    endfunction

    function automatic logic [MAX_AW-1:0] addr_tag(input logic [MAX_AW-1:0] addr, input int iw, input int ow);
        return addr >> (iw + ow);
    endfunction

endpackage

// File: rtl/core_icache_plru.sv
// core_icache_plru: per-set tree-PLRU state with victim lookup and two touch ports.
module core_icache_plru
    import core_icache_pkg::*;
#(
    parameter int NUM_WAYS    = 2,
    parameter int INDEX_WIDTH = 7,
    parameter int WAY_WIDTH   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic [INDEX_WIDTH-1:0] i_victim_idx,
    output logic [WAY_WIDTH-1:0]   o_victim,
    input  logic                   i_touch0,
    input  logic [INDEX_WIDTH-1:0] i_touch0_idx,
    input  logic [WAY_WIDTH-1:0]   i_touch0_way,
    input  logic                   i_touch1,
    input  logic [INDEX_WIDTH-1:0] i_touch1_idx,
    input  logic [WAY_WIDTH-1:0]   i_touch1_way
);

    localparam int SETS = 1 << INDEX_WIDTH;

    generate
        if (NUM_WAYS == 1) begin : g_direct
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_clear, i_victim_idx, i_touch0, i_touch0_idx,
                                i_touch0_way, i_touch1, i_touch1_idx, i_touch1_way};
            assign o_victim = '0;
        end else begin : g_tree
            logic [NUM_WAYS-2:0] r_tree [SETS];
            logic [NUM_WAYS-1:0] w_row0, w_row1;

            // Heap-ordered nodes: bit 0 sends the victim to the lower half, 1 to the upper half.
            function automatic logic [WAY_WIDTH-1:0] f_victim(input logic [NUM_WAYS-1:0] row);
                logic [WAY_WIDTH:0] node;
                node = (WAY_WIDTH + 1)'(1);
                for (int l = 0; l < WAY_WIDTH; l++)
                    node = {node[WAY_WIDTH-1:0], row[WAY_WIDTH'(node - 1'b1)]};
                return node[WAY_WIDTH-1:0];
            endfunction

            function automatic logic [NUM_WAYS-1:0] f_touch(input logic [NUM_WAYS-1:0] row,
                                                            input logic [WAY_WIDTH-1:0] way);
                logic [WAY_WIDTH:0] node;
                f_touch = row;
                node = {1'b1, way};
                for (int l = 0; l < WAY_WIDTH; l++) begin
                    f_touch[WAY_WIDTH'((node >> 1) - 1'b1)] = ~node[0];
                    node = node >> 1;
                end
            endfunction

            assign o_victim = f_victim({1'b0, r_tree[i_victim_idx]});
            assign w_row0   = f_touch({1'b0, r_tree[i_touch0_idx]}, i_touch0_way);
            assign w_row1   = f_touch({1'b0, r_tree[i_touch1_idx]}, i_touch1_way);

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst || i_clear) begin
                    r_tree <= '{default: '0};
                end else begin
                    if (i_touch0) r_tree[i_touch0_idx] <= w_row0[NUM_WAYS-2:0];
                    if (i_touch1) r_tree[i_touch1_idx] <= w_row1[NUM_WAYS-2:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/core_icache_assoc_memory.sv
// core_icache_assoc_memory: N-way instruction-cache arrays with lookup, two-line refill and flush sequencing.
module core_icache_assoc_memory
    import core_icache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 32,
    parameter int LINE_WIDTH      = 256,
    parameter int INDEX_WIDTH     = 7,
    parameter int NUM_WAYS        = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [ADDR_WIDTH-1:0]      i_req_addr,
    output logic                       o_rsp_valid,
    output logic [CORE_DATA_WIDTH-1:0] o_rsp_data,
    input  logic                       i_flush,
    output logic                       o_flush_done,
    output logic                       o_refill_req,
    output logic [ADDR_WIDTH-1:0]      o_refill_addr,
    input  logic                       i_refill_valid,
    input  logic [LINE_WIDTH-1:0]      i_refill_data
);

    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int SETS         = 1 << INDEX_WIDTH;
    localparam int WAY_WIDTH    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    state_t r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]      r_addr_a, r_refill_addr;
    logic                       r_miss_b, r_rsp_valid;
    logic [CORE_DATA_WIDTH-1:0] r_rsp_data;

    logic [LINE_WIDTH-1:0] r_data  [NUM_WAYS][SETS];
    logic [TAG_WIDTH-1:0]  r_tag   [NUM_WAYS][SETS];
    logic [SETS-1:0]       r_valid [NUM_WAYS];

    logic [ADDR_WIDTH-1:0]      w_addr_b, w_miss_line;
    logic [TAG_WIDTH-1:0]       w_tag_a, w_tag_b, w_rf_tag;
    logic [INDEX_WIDTH-1:0]     w_idx_a, w_idx_b, w_rf_idx, w_touch0_idx;
    logic [OFFSET_WIDTH-1:0]    w_off_a;
    logic [OFFSET_WIDTH:0]      w_pos;
    logic                       w_need_b, w_hit_a, w_hit_b, w_hit_all;
    logic [WAY_WIDTH-1:0]       w_hway_a, w_hway_b, w_victim, w_plru_victim, w_touch0_way;
    logic [LINE_WIDTH-1:0]      w_line_a, w_line_b;
    logic [CORE_DATA_WIDTH-1:0] w_word;
    logic                       w_accept, w_lookup_hit, w_fill, w_flush_start;

    // The last byte decides whether the word spills into the following line.
    assign w_addr_b = r_addr_a + ADDR_WIDTH'(3);
    assign w_tag_a  = TAG_WIDTH'(addr_tag(MAX_AW'(r_addr_a), INDEX_WIDTH, OFFSET_WIDTH));
    assign w_idx_a  = INDEX_WIDTH'(addr_index(MAX_AW'(r_addr_a), INDEX_WIDTH, OFFSET_WIDTH));
    assign w_off_a  = OFFSET_WIDTH'(addr_offset(MAX_AW'(r_addr_a), OFFSET_WIDTH));
    assign w_tag_b  = TAG_WIDTH'(addr_tag(MAX_AW'(w_addr_b), INDEX_WIDTH, OFFSET_WIDTH));
    assign w_idx_b  = INDEX_WIDTH'(addr_index(MAX_AW'(w_addr_b), INDEX_WIDTH, OFFSET_WIDTH));
    assign w_need_b = r_addr_a[ADDR_WIDTH-1:OFFSET_WIDTH] != w_addr_b[ADDR_WIDTH-1:OFFSET_WIDTH];

    always_comb begin
        w_hit_a  = 1'b0;
        w_hit_b  = 1'b0;
        w_hway_a = '0;
        w_hway_b = '0;
        w_line_a = '0;
        w_line_b = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w][w_idx_a] && r_tag[w][w_idx_a] == w_tag_a) begin
                w_hit_a  = 1'b1;
                w_hway_a = WAY_WIDTH'(w);
                w_line_a = r_data[w][w_idx_a];
            end
            if (r_valid[w][w_idx_b] && r_tag[w][w_idx_b] == w_tag_b) begin
                w_hit_b  = 1'b1;
                w_hway_b = WAY_WIDTH'(w);
                w_line_b = r_data[w][w_idx_b];
            end
        end
    end

    assign w_hit_all = w_hit_a && (!w_need_b || w_hit_b);

    always_comb begin
        w_word = '0;
        w_pos  = '0;
        for (int k = 0; k < CORE_DATA_WIDTH / 8; k++) begin
            w_pos = {1'b0, w_off_a} + (OFFSET_WIDTH + 1)'(k);
            w_word[8*k +: 8] = w_pos[OFFSET_WIDTH] ? w_line_b[{w_pos[OFFSET_WIDTH-1:0], 3'b000} +: 8]
                                                   : w_line_a[{w_pos[OFFSET_WIDTH-1:0], 3'b000} +: 8];
        end
    end

    assign w_rf_idx = r_miss_b ? w_idx_b : w_idx_a;
    assign w_rf_tag = r_miss_b ? w_tag_b : w_tag_a;

    always_comb begin
        w_victim = w_plru_victim;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!r_valid[w][w_rf_idx]) w_victim = WAY_WIDTH'(w);
    end

    assign w_accept      = o_req_ready && i_req_valid;
    assign w_lookup_hit  = (r_state == LOOKUP) && w_hit_all;
    assign w_fill        = (r_state == REFILL) && i_refill_valid;
    assign w_flush_start = (r_state == IDLE) && i_flush;
    assign w_touch0_idx  = w_fill ? w_rf_idx : w_idx_a;
    assign w_touch0_way  = w_fill ? w_victim : w_hway_a;
    assign w_miss_line   = w_hit_a ? w_addr_b : r_addr_a;

    core_icache_plru #(
        .NUM_WAYS    (NUM_WAYS),
        .INDEX_WIDTH (INDEX_WIDTH),
        .WAY_WIDTH   (WAY_WIDTH)
    ) u_plru (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_flush_start),
        .i_victim_idx (w_rf_idx),
        .o_victim     (w_plru_victim),
        .i_touch0     (w_lookup_hit || w_fill),
        .i_touch0_idx (w_touch0_idx),
        .i_touch0_way (w_touch0_way),
        .i_touch1     (w_lookup_hit && w_need_b),
        .i_touch1_idx (w_idx_b),
        .i_touch1_way (w_hway_b)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = !i_flush;
                if (i_flush)          w_state_next = FLUSH;
                else if (i_req_valid) w_state_next = LOOKUP;
            end
            LOOKUP:  w_state_next = w_hit_all ? IDLE : REFILL;
            REFILL:  if (i_refill_valid) w_state_next = LOOKUP;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr_a      <= '0;
            r_refill_addr <= '0;
            r_miss_b      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_valid       <= '{default: '0};
        end else begin
            r_rsp_valid <= w_lookup_hit;
            if (w_accept) r_addr_a <= i_req_addr;
            if (w_lookup_hit) r_rsp_data <= w_word;
            if (r_state == LOOKUP && !w_hit_all) begin
                r_miss_b      <= w_hit_a;
                r_refill_addr <= {w_miss_line[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
            end
            if (w_flush_start) r_valid <= '{default: '0};
            else if (w_fill)   r_valid[w_victim][w_rf_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_data[w_victim][w_rf_idx] <= i_refill_data;
            r_tag[w_victim][w_rf_idx]  <= w_rf_tag;
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_flush_done  = r_state == FLUSH;
    assign o_refill_req  = r_state == REFILL;
    assign o_refill_addr = r_refill_addr;

endmodule

// File: doc/core_icache_assoc_memory.md
# core_icache_assoc_memory

Parametrised N-way set-associative instruction-cache storage with integrated lookup/refill sequencing. It sits between the core fetch port and the AXI line-fill engine, and holds data, tag and valid arrays plus per-set tree-PLRU state. It returns any byte-aligned 32-bit fetch word, including words that straddle two lines, by refilling up to two lines through a single request/response handshake.

## Interface
- `ADDR_WIDTH`, 64: byte address width.
- `CORE_DATA_WIDTH`, 32: fetch word width. Fixed at 32.
- `LINE_WIDTH`, 256: line width in bits. Equals the AXI beat width. Power of two, ≥64.
- `INDEX_WIDTH`, 7: set index bits. Must be ≥1.
- `NUM_WAYS`, 2: associativity. Power of two, 1..8.
- Derived: `OFFSET_WIDTH`=log2(LINE_WIDTH/8); `TAG_WIDTH`=ADDR_WIDTH−INDEX_WIDTH−OFFSET_WIDTH.
- `i_clk` input 1: single clock, rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_req_valid` input 1: fetch request.
- `o_req_ready` output 1: request accepted when valid&&ready.
- `i_req_addr` input ADDR_WIDTH: fetch byte address. Any alignment.
- `o_rsp_valid` output 1: one-cycle pulse, fetch word valid.
- `o_rsp_data` output 32: little-endian word from bytes addr..addr+3.
- `i_flush` input 1: invalidate all lines (fence.i). Level, held until done.
- `o_flush_done` output 1: one-cycle pulse.
- `o_refill_req` output 1: line fill request. Held until `i_refill_valid`.
- `o_refill_addr` output ADDR_WIDTH: line-aligned address. Stable while `o_refill_req`.
- `i_refill_valid` input 1: fill data valid. Completes the request.
- `i_refill_data` input LINE_WIDTH: line data, byte 0 at bits [7:0].

## Operation
- FSM states: IDLE, LOOKUP, REFILL, FLUSH.
- IDLE:
  - `o_req_ready`=!i_flush.
  - If `i_flush` → FLUSH.
  - Else on accept, register the address → LOOKUP.
- LOOKUP:
  - Line A = addr. Line B = addr+3 (mod 2^ADDR_WIDTH). B is needed only if its line differs from A.
  - Set B index = A index+1 mod 2^INDEX_WIDTH. Tag increments on index wrap.
  - Compare tags across all ways with valid bits.
  - All needed lines hit: register `o_rsp_data`, pulse `o_rsp_valid` next cycle, touch PLRU for each hit line, → IDLE.
  - Otherwise → REFILL for the first missing line, A before B.
- REFILL:
  - `o_refill_req`=1. `o_refill_addr`= missing line address with offset bits zeroed.
  - On `i_refill_valid`: write data, tag and valid=1 into the victim way, make that way MRU in PLRU, → LOOKUP (re-lookup).
  - `i_refill_valid` outside REFILL is ignored.
- Victim selection: lowest-index invalid way; otherwise the tree-PLRU victim. For NUM_WAYS=1, always way 0.
- FLUSH: clear all valid bits and PLRU state, pulse `o_flush_done` next cycle, → IDLE.
- Requests and flush are never accepted outside IDLE. A flush waiting in IDLE has priority over a request.
- Byte extraction: byte k (k=0..3) comes from address addr+k. Its line is A or B, chosen by whether the offset wraps past LINE_WIDTH/8−1.

## Timing
- Hit: accept at edge N, `o_rsp_valid` high during cycle N+2. This coincides with IDLE, so a new request can be accepted in the same cycle (throughput 1 per 2 cycles).
- Miss: `o_refill_req` rises in the cycle after LOOKUP. After `i_refill_valid` at edge M, LOOKUP runs in cycle M+1.
  - Single miss: response in cycle M+2.
  - Straddling double miss: two sequential refills.
- Flush: i_flush sampled in IDLE at edge F, `o_flush_done` in cycle F+1. Lookups after that edge see all lines invalid.
- Reset values:
  - State IDLE.
  - `o_req_ready`=1. `o_rsp_valid`, `o_rsp_data`, `o_flush_done`, `o_refill_req`, `o_refill_addr` all 0.
  - All valid bits 0, PLRU 0.
  - Data and tag arrays are not reset, so they map to SRAM.
- Reset mid-refill: `o_refill_req` drops asynchronously. No array write occurs. The in-flight response is dropped.

## Structure
- Package `core_icache_pkg`: state enum, and TAG/INDEX/OFFSET extraction functions parametrised by the widths above.
- Sub-module `core_icache_plru`: per-set tree-PLRU storage (NUM_WAYS−1 bits per set). It provides the victim output and update-on-touch, with reset/clear input.

## Test plan
- Miss then fill:
  - Stimulus: reset, request 0x1000.
  - Required response: `o_refill_req` with addr 0x1000. Supply bytes 0x00..0x1F. `o_rsp_data`=0x03020100 two cycles after `i_refill_valid`.
- Hit: request 0x1004 → `o_rsp_data`=0x07060504 at N+2, no `o_refill_req`.
- Straddle:
  - Stimulus: with 0x1000 resident, request 0x101E.
  - Required response: a single refill at 0x1020 (bytes 0x20..0x3F), then `o_rsp_data`=0x21201F1E.
- Eviction (2 ways):
  - Stimulus: fill 0x1000 and 0x2000, hit 0x1000, request 0x3000.
  - Required response: the way holding 0x2000 is replaced. A following request to 0x1000 hits; a request to 0x2000 misses.
- Flush: i_flush held 1 in IDLE → `o_req_ready`=0, `o_flush_done` next cycle, subsequent request to 0x1000 misses.
- Reset in REFILL: assert `i_rst` while `o_refill_req`=1 → all outputs 0 immediately; a late `i_refill_valid` is ignored; the next request misses.
